// File: rtl/mem_handshake_ram.sv
// 256-byte big-endian RAM behind a four-phase MOV/MOC handshake with WAIT_CYCLES wait states.
// Define ALIGN_CHECK_EN to reject misaligned halfword/word accesses with ERR.
module mem_handshake_ram #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MOV,
  input  logic        R_W,
  input  logic [1:0]  DT,
  input  logic [7:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MOC,
  output logic        ERR
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rw_q;
  logic [1:0]  dt_q;
  logic [7:0]  a_q;
  logic [31:0] d_q;
  logic [7:0]  mem [0:255];

  logic        bad;
  logic        access;
  logic        commit;
  logic [7:0]  a1, a2, a3;
  logic [31:0] rd_word, rd_data, wr_data;

  always_comb begin
    a1 = a_q + 8'd1;
    a2 = a_q + 8'd2;
    a3 = a_q + 8'd3;
    bad = (dt_q == 2'b11);
`ifdef ALIGN_CHECK_EN
    bad = bad | ((dt_q == 2'b01) && a_q[0]) | ((dt_q == 2'b10) && (a_q[1:0] != 2'b00));
`endif
    access = (state == WAIT) && (cnt == 4'd0);
    // clr on the completing edge must win over the write
    commit = access && !clr && !bad && !rw_q;
    rd_word = {mem[a_q], mem[a1], mem[a2], mem[a3]};
    case (dt_q)
      2'b00:   rd_data = {24'b0, rd_word[31:24]};
      2'b01:   rd_data = {16'b0, rd_word[31:16]};
      default: rd_data = rd_word;
    endcase
    case (dt_q)
      2'b00:   wr_data = {d_q[7:0], 24'b0};
      2'b01:   wr_data = {d_q[15:0], 16'b0};
      default: wr_data = d_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[a_q] <= wr_data[31:24];
      if (dt_q != 2'b00) mem[a1] <= wr_data[23:16];
      if (dt_q == 2'b10) begin
        mem[a2] <= wr_data[15:8];
        mem[a3] <= wr_data[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      MOC      <= 1'b0;
      ERR      <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            rw_q  <= R_W;
            dt_q  <= DT;
            a_q   <= address;
            d_q   <= data_in;
            cnt   <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ACK;
            MOC   <= 1'b1;
            ERR   <= bad;
            if (rw_q && !bad) data_out <= rd_data;
          end
        end
        ACK: begin
          if (!MOV) begin
            state <= IDLE;
            MOC   <= 1'b0;
            ERR   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Randomized bench for mem_handshake_ram: transaction-level model predicts MOC/ERR/data_out each cycle.
// Honours ALIGN_CHECK_EN the same way as the design.
module tb_mem_handshake_ram;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        clr, mov, r_w;
  logic [1:0]  dt_s;
  logic [7:0]  address;
  logic [31:0] data_in, data_out;
  logic        moc, err;

  logic        mov0, rw0;
  logic [1:0]  dt0;
  logic [7:0]  a0;
  logic [31:0] d0, dout0;
  logic        moc0, err0;

  mem_handshake_ram #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .clr(clr), .MOV(mov), .R_W(r_w), .DT(dt_s), .address(address),
    .data_in(data_in), .data_out(data_out), .MOC(moc), .ERR(err)
  );

  mem_handshake_ram #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clr(clr), .MOV(mov0), .R_W(rw0), .DT(dt0), .address(a0),
    .data_in(d0), .data_out(dout0), .MOC(moc0), .ERR(err0)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  model_mem [256];
  logic        exp_moc, exp_err;
  logic [31:0] exp_dout;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level access: ERR rules, then read or write of 1<<dt bytes, big-endian, wrapping.
  task automatic model_access(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                              input logic [31:0] d);
    bit bad;
    int n;
    logic [31:0] v;
    bad = (dt == 2'b11);
`ifdef ALIGN_CHECK_EN
    if (dt == 2'b01 && a % 2 != 0) bad = 1'b1;
    if (dt == 2'b10 && a % 4 != 0) bad = 1'b1;
`endif
    exp_moc = 1'b1;
    exp_err = bad;
    if (!bad) begin
      n = 1 << dt;
      if (rw) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[(int'(a) + i) % 256]);
        exp_dout = v;
      end else begin
        for (int i = 0; i < n; i++) model_mem[(int'(a) + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
      end
    end
  endtask

  // One request; MOV is sampled high on mov_len consecutive edges. Returns right after the edge
  // that brings the handshake back to idle.
  task automatic do_access(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                           input logic [31:0] d, input int unsigned mov_len);
    int unsigned hi, k;
    bit done, mov_sampled;
    @(negedge clk);
    mov = 1'b1; r_w = rw; dt_s = dt; address = a; data_in = d;
    @(posedge clk);
    hi = 1; k = 0; done = 1'b0;
    while (!done && k < W + mov_len + 8) begin
      @(negedge clk);
      if (hi < mov_len) begin mov = 1'b1; hi++; end
      else mov = 1'b0;
      r_w = 1'($urandom); dt_s = 2'($urandom); address = 8'($urandom); data_in = $urandom;
      mov_sampled = mov;
      @(posedge clk);
      k++;
      if (k == W + 1) model_access(rw, dt, a, d);
      else if (k > W + 1 && !mov_sampled) begin
        exp_moc = 1'b0;
        exp_err = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_fail++;
      $display("FAIL handshake_timeout: got no return to idle expected return within %0d edges", k);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      check("moc", 32'(moc), 32'(exp_moc));
      check("err", 32'(err), 32'(exp_err));
      check("data_out", data_out, exp_dout);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; mov = 1'b0; r_w = 1'b0; dt_s = 2'b00; address = '0; data_in = '0;
    mov0 = 1'b0; rw0 = 1'b0; dt0 = 2'b00; a0 = '0; d0 = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_moc", 32'(moc), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_dout", data_out, 32'd0);
    check("reset_moc0", 32'(moc0), 32'd0);
    check("reset_dout0", dout0, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = '0;
    chk_en = 1'b1;

    for (int i = 0; i < 64; i++) do_access(1'b0, 2'b10, 8'(i * 4), $urandom, 1);

    do_access(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 1);
    do_access(1'b1, 2'b00, 8'h10, $urandom, 2);
    #2 check("byte_read_10", data_out, 32'h000000DE);
    do_access(1'b1, 2'b01, 8'h12, $urandom, 1);
    #2 check("half_read_12", data_out, 32'h0000BEEF);

    do_access(1'b1, 2'b10, 8'h10, 32'h0, 6);
    #2 check("long_hold_word", data_out, 32'hDEADBEEF);

    do_access(1'b0, 2'b10, 8'hFC, 32'h11223344, 1);
    do_access(1'b0, 2'b10, 8'h00, 32'h55667788, 1);
    do_access(1'b1, 2'b10, 8'hFE, $urandom, 1);
`ifdef ALIGN_CHECK_EN
    #2 check("misaligned_word_kept", data_out, 32'hDEADBEEF);
    do_access(1'b1, 2'b10, 8'h01, $urandom, 1);
    #2 check("misaligned_01_kept", data_out, 32'hDEADBEEF);
`else
    #2 check("wrap_word_fe", data_out, 32'h33445566);
`endif

    do_access(1'b0, 2'b11, 8'h00, 32'h12345678, 2);
    do_access(1'b1, 2'b10, 8'h00, $urandom, 1);
    #2 check("illegal_dt_no_write", data_out, 32'h55667788);

    // Byte write aborted by clr during the wait states.
    @(negedge clk);
    mov = 1'b1; r_w = 1'b0; dt_s = 2'b00; address = 8'h20; data_in = 32'h55;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = '0;
    #2;
    check("clr_abort_moc", 32'(moc), 32'd0);
    check("clr_abort_dout", data_out, 32'd0);
    @(negedge clk);
    clr = 1'b0; mov = 1'b0;
    do_access(1'b1, 2'b00, 8'h20, $urandom, 1);
    #2 check("clr_abort_mem", data_out, {24'b0, model_mem[8'h20]});

    for (int t = 0; t < 300; t++) begin
      logic [1:0] dtr;
      logic [7:0] ar;
      dtr = 2'($urandom_range(0, 3));
      ar = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      do_access(1'($urandom_range(0, 2) != 0), dtr, ar, $urandom, $urandom_range(1, 5));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Zero wait states: one-cycle MOV pulse still completes with a one-cycle MOC.
    @(negedge clk);
    mov0 = 1'b1; rw0 = 1'b0; dt0 = 2'b00; a0 = 8'h40; d0 = 32'h000000A5;
    @(posedge clk); #2 check("w0_wr_moc_edge0", 32'(moc0), 32'd0);
    @(negedge clk); mov0 = 1'b0;
    @(posedge clk); #2 check("w0_wr_moc_edge1", 32'(moc0), 32'd1);
    @(posedge clk); #2 check("w0_wr_moc_edge2", 32'(moc0), 32'd0);
    @(negedge clk);
    mov0 = 1'b1; rw0 = 1'b1; a0 = 8'h40;
    @(posedge clk);
    @(negedge clk); mov0 = 1'b0;
    @(posedge clk); #2;
    check("w0_rd_moc_edge1", 32'(moc0), 32'd1);
    check("w0_rd_data", dout0, 32'h000000A5);
    @(posedge clk); #2 check("w0_rd_moc_edge2", 32'(moc0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
